instruction_fetch_unit: RTL

//  Fetch stage of the processor; sits directly upstream of the instruction memory.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit_pc_register.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: widths, opcode field, NOP/HALT encodings and fetch FSM states.
// HALT_OPCODE only has an effect when FETCH_HALT_DETECT_EN is defined.
package cpu_pkg;

    localparam int PC_W       = 10;
    localparam int INSTR_W    = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [INSTR_W-1:0]            NOP_WORD    = '0;
    localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_halt_word(input logic [INSTR_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and decode, plus the fetch FSM debug state.
// if_valid qualifies the IF/ID word; decode holds it with stall=1 and takes it on any edge with stall=0.
interface instruction_fetch_unit_if;
    import cpu_pkg::*;

    logic               stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic [PC_W-1:0]    if_pc_plus1;
    logic               if_valid;
    logic               halted;
    fetch_state_t       dbg_state;

    modport master (
        input  stall, redirect, redirect_pc, imem_data,
        output imem_addr, if_instr, if_pc, if_pc_plus1, if_valid, halted, dbg_state
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_data,
        input  imem_addr, if_instr, if_pc, if_pc_plus1, if_valid, halted, dbg_state
    );

endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter: synchronous reset to RESET_PC, load beats advance, arithmetic wraps mod 2^PC_W.
module pc_register
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            advance,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    assign pc       = pc_q;
    assign pc_plus1 = pc_q + PC_W'(1);

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (advance) begin
            pc_d = pc_plus1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 10'd0,
    parameter int              IMEM_DEPTH  = 31,
    parameter int              BOOT_CYCLES = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    localparam int                BOOT_W    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [PC_W:0]     DEPTH_LIM = (PC_W + 1)'(IMEM_DEPTH);

    fetch_state_t       state_q, state_d;
    logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic [PC_W-1:0]    if_pc_plus1_q, if_pc_plus1_d;
    logic               if_valid_q, if_valid_d;
`ifdef FETCH_HALT_DETECT_EN
    logic               halted_q, halted_d;
`endif

    logic               pc_load;
    logic               pc_advance;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
    logic [INSTR_W-1:0] fetched;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clock    (clock),
        .reset    (reset),
        .load     (pc_load),
        .advance  (pc_advance),
        .load_pc  (bus.redirect_pc),
        .pc       (pc),
        .pc_plus1 (pc_plus1)
    );

    // Addresses past the populated memory read back as NOP rather than faulting.
    assign fetched = ({1'b0, pc} < DEPTH_LIM) ? bus.imem_data : NOP_WORD;

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        if_instr_d    = if_instr_q;
        if_pc_d       = if_pc_q;
        if_pc_plus1_d = if_pc_plus1_q;
        if_valid_d    = if_valid_q;
`ifdef FETCH_HALT_DETECT_EN
        halted_d      = halted_q;
`endif
        pc_load       = 1'b0;
        pc_advance    = 1'b0;

        case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                end
            end
            RUN: begin
                // A redirect flushes the wrong-path word even while decode is stalled.
                if (bus.redirect) begin
                    pc_load    = 1'b1;
                    if_valid_d = 1'b0;
                end else if (!bus.stall) begin
                    if_instr_d    = fetched;
                    if_pc_d       = pc;
                    if_pc_plus1_d = pc_plus1;
                    if_valid_d    = 1'b1;
                    pc_advance    = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
                    if (is_halt_word(fetched)) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end
`endif
                end
            end
`ifdef FETCH_HALT_DETECT_EN
            HALT: begin
                if_valid_d = 1'b0;
                if (bus.redirect) begin
                    pc_load  = 1'b1;
                    halted_d = 1'b0;
                    state_d  = RUN;
                end
            end
`endif
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BOOT;
            boot_cnt_q    <= '0;
            if_instr_q    <= '0;
            if_pc_q       <= '0;
            if_pc_plus1_q <= '0;
            if_valid_q    <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            halted_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            if_instr_q    <= if_instr_d;
            if_pc_q       <= if_pc_d;
            if_pc_plus1_q <= if_pc_plus1_d;
            if_valid_q    <= if_valid_d;
`ifdef FETCH_HALT_DETECT_EN
            halted_q      <= halted_d;
`endif
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.if_instr    = if_instr_q;
    assign bus.if_pc       = if_pc_q;
    assign bus.if_pc_plus1 = if_pc_plus1_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.dbg_state   = state_q;
`ifdef FETCH_HALT_DETECT_EN
    assign bus.halted      = halted_q;
`else
    assign bus.halted      = 1'b0;
`endif

endmodule
